// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
// Long-press logic is controlled by the DEBOUNCE_LONGPRESS_EN macro in debounce_channel.
package debounce_pkg;

    localparam int TICK_DIV_1MS_50M     = 50000;
    localparam int STABLE_TICKS_DEFAULT = 20;
    localparam int LONG_TICKS_DEFAULT   = 1000;

    // Width needed to hold the values 0..n-1. The result is never less than
    // one bit, so degenerate parameters still give legal vectors.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer lane: synchroniser, stability counter, rise/fall pulses and,
// when DEBOUNCE_LONGPRESS_EN is defined, a one-shot long-press detector.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int LONG_TICKS   = LONG_TICKS_DEFAULT
) (
    input  logic clk_50M,
    input  logic reset_n,
    input  logic tick,
    input  logic inp,
    output logic outp,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int CW = cnt_width(STABLE_TICKS);

    if (SYNC_STAGES < 2 || STABLE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
        $error("debounce_channel: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   outp_q, outp_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], inp};
        cnt_d  = cnt_q;
        outp_d = outp_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Agreement on any cycle restarts the count, so short glitches of
        // either polarity never accumulate.
        if (s == outp_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                outp_d = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            outp_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            outp_q <= outp_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign outp = outp_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LW = cnt_width(LONG_TICKS + 1);

    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          hold_q, hold_d;

    // lcnt saturates at LONG_TICKS so a held button fires exactly once.
    always_comb begin
        lcnt_d = lcnt_q;
        hold_d = 1'b0;
        if (!outp_q) begin
            lcnt_d = '0;
        end else if (tick && (lcnt_q != LW'(LONG_TICKS))) begin
            lcnt_d = lcnt_q + LW'(1);
            hold_d = (lcnt_q == LW'(LONG_TICKS - 1));
        end
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            lcnt_q <= '0;
            hold_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            hold_q <= hold_d;
        end
    end

    assign hold = hold_q;
`else
    assign hold = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel debouncer top: one free-running sample-tick prescaler shared by
// an array of debounce_channel lanes. Long-press needs DEBOUNCE_LONGPRESS_EN.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = TICK_DIV_1MS_50M,
    parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int LONG_TICKS   = LONG_TICKS_DEFAULT
) (
    input  logic                clk_50M,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] inp,
    output logic [CHANNELS-1:0] outp,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam int PW = cnt_width(TICK_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // With TICK_DIV == 1 the count sits at 0 and tick is permanently high.
    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_chan (
            .clk_50M (clk_50M),
            .reset_n (reset_n),
            .tick    (tick),
            .inp     (inp[gi]),
            .outp    (outp[gi]),
            .rise    (rise[gi]),
            .fall    (fall[gi]),
            .hold    (hold[gi])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Self-checking bench for multi_debounce: level vectors from a table plus a
// windowed pulse scoreboard; hold expectations follow DEBOUNCE_LONGPRESS_EN.
module tb_multi_debounce;

    localparam int CH = 4;

    logic          clk_50M = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] inp     = 4'hF;
    logic [CH-1:0] outp, rise, fall, hold;

    multi_debounce #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (2),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .LONG_TICKS   (5)
    ) dut (
        .clk_50M (clk_50M),
        .reset_n (reset_n),
        .inp     (inp),
        .outp    (outp),
        .rise    (rise),
        .fall    (fall),
        .hold    (hold)
    );

    always #5 clk_50M = ~clk_50M;

    // kind: 0 rise, 1 fall, 2 hold; pulse must appear within cycle lo..hi
    typedef struct {
        int ch;
        int kind;
        int lo;
        int hi;
    } exp_t;

    typedef struct {
        logic [CH-1:0] inp;
        int            dwell;
        logic [CH-1:0] exp_outp;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[6];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            k;
    logic [CH-1:0] model_outp;

    function automatic string kname(input int kind);
        return (kind == 0) ? "rise" : (kind == 1) ? "fall" : "hold";
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h required=%0h", name, cyc, act, req);
        end else begin
            $display("cycle %0d: %s ok value=%0h", cyc, name, act);
        end
    endtask

    task automatic push_exp(input int ch, input int kind, input int lo, input int hi);
        exp_t e;
        e.ch = ch; e.kind = kind; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    // Debounced edges land 11..14 cycles after the input edge; a long press
    // fires 17..20 cycles after the rise.
    task automatic push_changes(input logic [CH-1:0] prev, input logic [CH-1:0] nxt, input int at);
        for (int ch = 0; ch < CH; ch++) begin
            if (prev[ch] != nxt[ch]) begin
                push_exp(ch, nxt[ch] ? 0 : 1, at + 11, at + 14);
`ifdef DEBOUNCE_LONGPRESS_EN
                if (nxt[ch]) push_exp(ch, 2, at + 28, at + 34);
`endif
            end
        end
    endtask

    task automatic monitor();
        logic [CH-1:0] v;
        bit            found;
        for (int kind = 0; kind < 3; kind++) begin
            v = (kind == 0) ? rise : (kind == 1) ? fall : hold;
            for (int ch = 0; ch < CH; ch++) begin
                if (v[ch]) begin
                    found = 1'b0;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (!found && sb[i].ch == ch && sb[i].kind == kind &&
                            cyc >= sb[i].lo && cyc <= sb[i].hi) begin
                            found = 1'b1;
                            sb.delete(i);
                        end
                    end
                    checks++;
                    if (found) begin
                        $display("cycle %0d: %s[%0d] pulse matched", cyc, kname(kind), ch);
                    end else begin
                        failures++;
                        $display("FAIL unexpected_%s ch=%0d cycle=%0d got=pulse required=none",
                                 kname(kind), ch, cyc);
                    end
                end
            end
        end
        if ((rise | fall) != '0) check("rise_fall_exclusive", 32'(rise & fall), 32'd0);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].hi < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_%s ch=%0d cycle=%0d got=none required=pulse in %0d..%0d",
                         kname(sb[i].kind), sb[i].ch, cyc, sb[i].lo, sb[i].hi);
                sb.delete(i);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_50M);
            cyc++;
            monitor();
        end
    endtask

    initial begin
        vecs[0] = '{4'b0000, 40, 4'b0000};
        vecs[1] = '{4'b0001, 40, 4'b0001};
        vecs[2] = '{4'b0101, 40, 4'b0101};
        vecs[3] = '{4'b0100, 40, 4'b0100};
        vecs[4] = '{4'b1010, 40, 4'b1010};
        vecs[5] = '{4'b0000, 40, 4'b0000};

        // Reset with all inputs high: outputs held at zero, then four rises.
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("reset_outputs", 32'({outp, rise, fall, hold}), 32'd0);
        end
        reset_n = 1'b1;
        k = cyc;
        for (int ch = 0; ch < CH; ch++) begin
            push_exp(ch, 0, k + 12, k + 12);
`ifdef DEBOUNCE_LONGPRESS_EN
            push_exp(ch, 2, k + 28, k + 34);
`endif
        end
        step(40);
        check("release_outp", 32'(outp), 32'hF);
        model_outp = 4'hF;

        // Clean press/release, simultaneous changes, channel independence.
        for (int v = 0; v < 6; v++) begin
            inp = vecs[v].inp;
            push_changes(model_outp, vecs[v].exp_outp, cyc);
            model_outp = vecs[v].exp_outp;
            step(vecs[v].dwell);
            check($sformatf("vec%0d_outp", v), 32'(outp), 32'(vecs[v].exp_outp));
`ifndef DEBOUNCE_LONGPRESS_EN
            check($sformatf("vec%0d_hold", v), 32'(hold), 32'd0);
`endif
        end

        // Bounce on channel 1: 5-cycle intervals are all rejected.
        for (int t = 0; t < 12; t++) begin
            inp[1] = ~inp[1];
            step(5);
        end
        inp[1] = 1'b0;
        step(30);
        check("bounce_outp", 32'(outp), 32'd0);

        // Low-going 8-cycle glitch on a debounced-high channel is rejected.
        inp = 4'b0001;
        push_changes(4'b0000, 4'b0001, cyc);
        step(40);
        inp = 4'b0000;
        step(8);
        inp = 4'b0001;
        step(30);
        check("low_glitch_outp", 32'(outp), 32'h1);
        inp = 4'b0000;
        push_changes(4'b0001, 4'b0000, cyc);
        step(30);
        check("low_glitch_release", 32'(outp), 32'd0);

        // Reset mid-count: no pulse, then a fresh debounce after release.
        inp = 4'b1000;
        step(6);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("midreset_outputs", 32'({outp, rise, fall, hold}), 32'd0);
        end
        reset_n = 1'b1;
        k = cyc;
        push_exp(3, 0, k + 12, k + 12);
`ifdef DEBOUNCE_LONGPRESS_EN
        push_exp(3, 2, k + 28, k + 34);
`endif
        step(40);
        check("midreset_outp", 32'(outp), 32'h8);
        inp = 4'b0000;
        push_changes(4'b1000, 4'b0000, cyc);
        step(30);
        check("final_outp", 32'(outp), 32'd0);

        step(2);
        while (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_%s ch=%0d got=none required=pulse in %0d..%0d",
                     kname(sb[0].kind), sb[0].ch, sb[0].lo, sb[0].hi);
            void'(sb.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
